// File: rtl/bbmips_mem_resp.sv
// bbmips_mem_resp: memory target for the load/store stages.
// Accepts one request at a time over a valid/ready channel and holds a
// big-endian byte array. After LATENCY wait cycles it commits the access
// and presents a registered response until the initiator takes it.
module bbmips_mem_resp #(
  parameter int MEMSIZE = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // latched request
  logic        we_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  // registered response
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // byte array; contents survive reset
  logic [7:0] mem_q [MEMSIZE];

  logic accept, commit;

  // effective command: live inputs on the acceptance edge (needed when
  // LATENCY=0 commits on that same edge), latched copy otherwise
  logic        cmd_we, cmd_sext;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;

  logic [32:0]   nbytes, end_addr;
  logic          err_size, err_align, err_range, cmd_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rd_data;

  assign accept = req_valid_i & (state_q == S_IDLE);
  // commit happens on the edge that enters RESP
  assign commit = (state_d == S_RESP) & (state_q != S_RESP);

  // select live or latched request fields
  always_comb begin
    if (state_q == S_IDLE) begin
      cmd_we    = req_we_i;
      cmd_size  = req_size_i;
      cmd_sext  = req_sext_i;
      cmd_addr  = req_addr_i;
      cmd_wdata = req_wdata_i;
    end else begin
      cmd_we    = we_q;
      cmd_size  = size_q;
      cmd_sext  = sext_q;
      cmd_addr  = addr_q;
      cmd_wdata = wdata_q;
    end
  end

  // access checks; range is computed in 33 bits so a wrap past 2^32 errors
  always_comb begin
    case (cmd_size)
      2'd0:    nbytes = 33'd1;
      2'd1:    nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    end_addr  = {1'b0, cmd_addr} + nbytes;
    err_size  = (cmd_size == 2'd3);
    err_align = ((cmd_size == 2'd1) & cmd_addr[0]) |
                ((cmd_size == 2'd2) & (|cmd_addr[1:0]));
    err_range = (end_addr > 33'(MEMSIZE));
    cmd_err   = err_size | err_align | err_range;
  end

  // big-endian byte fetch and read extension
  always_comb begin
    idx0 = cmd_addr[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    b0   = mem_q[idx0];
    b1   = mem_q[idx1];
    b2   = mem_q[idx2];
    b3   = mem_q[idx3];
    rd_data = 32'd0;
    if (!cmd_we && !cmd_err) begin
      case (cmd_size)
        2'd0:    rd_data = {{24{cmd_sext & b0[7]}}, b0};
        2'd1:    rd_data = {{16{cmd_sext & b0[7]}}, b0, b1};
        2'd2:    rd_data = {b0, b1, b2, b3};
        default: rd_data = 32'd0;
      endcase
    end
  end

  // state register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state and response registers
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rsp_rdata_q;
    rsp_err_o   = rsp_err_q;
  end

  // request latch and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        sext_q  <= req_sext_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        rsp_rdata_q <= rd_data;
        rsp_err_q   <= cmd_err;
      end
    end
  end

  // array write on the commit edge; reset suppresses an in-flight write
  always_ff @(posedge clk) begin
    if (rst_n && commit && cmd_we && !cmd_err) begin
      case (cmd_size)
        2'd0: mem_q[idx0] <= cmd_wdata[7:0];
        2'd1: begin
          mem_q[idx0] <= cmd_wdata[15:8];
          mem_q[idx1] <= cmd_wdata[7:0];
        end
        2'd2: begin
          mem_q[idx0] <= cmd_wdata[31:24];
          mem_q[idx1] <= cmd_wdata[23:16];
          mem_q[idx2] <= cmd_wdata[15:8];
          mem_q[idx3] <= cmd_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bbmips_mem_resp.sv
// Directed bench for bbmips_mem_resp: a LATENCY=2 instance for the main
// sequence and a LATENCY=0 instance for the zero-wait case.
module tb_bbmips_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        req_we = 1'b0, req_sext = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        rsp_ready = 1'b0, rsp_ready0 = 1'b0;
  logic        req_ready, req_ready0, rsp_valid, rsp_valid0, rsp_err, rsp_err0;
  logic [31:0] rsp_rdata, rsp_rdata0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bbmips_mem_resp #(.MEMSIZE(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_sext_i(req_sext), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  bbmips_mem_resp #(.MEMSIZE(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we),
    .req_size_i(req_size), .req_sext_i(req_sext), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present a request to the LATENCY=2 instance for its acceptance edge,
  // then scramble the request lines to show they are not re-sampled
  task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sext = sx;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'd3; req_sext = ~sx;
    req_addr = 32'hA5A5_A5A5; req_wdata = 32'h5A5A_5A5A;
  endtask

  // bounded wait for rsp_valid; also checks the LATENCY+1 edge timing
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {31'd0, req_ready & ~rsp_valid}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    issue(we, sz, sx, a, wd);
    wait_rsp(tag);
    chk({tag, "_rd"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    finish_rsp(tag);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic word write/read and sub-word reads, big-endian
    txn("wr_w10",   1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
    txn("rd_w10",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
    txn("rd_b10",   1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0000_0011, 1'b0);
    txn("rd_h12",   1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_3344, 1'b0);
    txn("wr_b13",   1'b1, 2'd0, 1'b0, 32'h13, 32'hAAAA_AAF0, 32'h0, 1'b0);
    txn("rd_b13s",  1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFF0, 1'b0);
    txn("rd_b13z",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_00F0, 1'b0);
    txn("rd_w10b",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1122_33F0, 1'b0);
    txn("rd_h12s",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_33F0, 1'b0);
    txn("wr_h10",   1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_8899, 32'h0, 1'b0);
    txn("rd_h10s",  1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'hFFFF_8899, 1'b0);
    txn("rd_w10c",  1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h8899_33F0, 1'b0);

    // error paths
    txn("rd_w02",   1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    txn("wr_w04",   1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFE_BABE, 32'h0, 1'b0);
    txn("wr_h05",   1'b1, 2'd1, 1'b0, 32'h05, 32'h0000_1234, 32'h0, 1'b1);
    txn("rd_w04",   1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'hCAFE_BABE, 1'b0);
    txn("rd_sz3",   1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("wr_sz3",   1'b1, 2'd3, 1'b0, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("rd_w04b",  1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'hCAFE_BABE, 1'b0);

    // range limits
    txn("wr_w3fc",  1'b1, 2'd2, 1'b0, 32'h3FC, 32'hA1B2_C3D4, 32'h0, 1'b0);
    txn("rd_w3fc",  1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'hA1B2_C3D4, 1'b0);
    txn("rd_b3ff",  1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0, 32'h0000_00D4, 1'b0);
    txn("rd_w400",  1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    txn("rd_b400",  1'b0, 2'd0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    txn("rd_wwrap", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

    // backpressure with a competing request held high
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp("bp");
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h10; req_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h8899_33F0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_valid_after", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("bp_not_taken", {31'd0, req_ready}, 32'd1);
    txn("rd_w10d",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8899_33F0, 1'b0);

    // reset during WAIT drops the pending write
    txn("wr_w20",   1'b1, 2'd2, 1'b0, 32'h20, 32'h0102_0304, 32'h0, 1'b0);
    txn("rd_w20",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0102_0304, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
    chk("mid_in_wait", {31'd0, req_ready | rsp_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rdata", rsp_rdata, 32'd0);
    chk("mid_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn("rd_w20b",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0102_0304, 1'b0);

    // zero-latency instance: response on the acceptance edge
    req_valid0 = 1'b1; req_we = 1'b1; req_size = 2'd2; req_sext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h5566_7788;
    chk("l0_pre_valid", {31'd0, rsp_valid0}, 32'd0);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("l0_wr_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("l0_wr_err", {31'd0, rsp_err0}, 32'd0);
    chk("l0_wr_ready", {31'd0, req_ready0}, 32'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    chk("l0_idle", {31'd0, req_ready0 & ~rsp_valid0}, 32'd1);
    req_valid0 = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("l0_rd_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("l0_rd_data", rsp_rdata0, 32'h5566_7788);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h3FE;
    rsp_ready0 = 1'b0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("l0_err_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("l0_err", {31'd0, rsp_err0}, 32'd1);
    chk("l0_err_rdata", rsp_rdata0, 32'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
